result_display_driver: RTL
==========================

# result_display_driver

Downstream consumer of the register-bank/ALU datapath result. Captures a 32-bit ALU result through a valid/ready handshake and alternates the upper and lower 16-bit halves on a raw `display` bus. It also drives a 4-digit, time-multiplexed, active-low seven-segment display showing the current half in hex. A guaranteed minimum show window makes each captured result visible in both halves before the next one is accepted.

## Interface

- `HALF_TICKS`, default 50000000: clock cycles each half stays displayed (≥2).
- `SCAN_TICKS`, default 50000: clock cycles each digit stays lit per scan step (≥1).

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `result_valid`  in  1  producer has a result on `result`.
- `result`  in  32  ALU result to display.
- `result_ready`  out  1  block will accept a result this cycle.
- `display`  out  16  raw half currently shown (registered).
- `half_sel`  out  1  0 = upper half [31:16], 1 = lower half [15:0].
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit anodes, active-low; `an[3]` = most significant nibble.

## Operation

- Capture occurs on any rising edge with `result_valid && result_ready && rst_n`. The word goes to internal `value`.
- FSM states:
  - EMPTY (reset state): no result yet; `an`=4'hF (blank); ready=1.
  - SHOW_HI: ready=0; `half_sel`=0.
  - SHOW_LO: ready=0; `half_sel`=1.
  - FREE: ready=1; `half_sel` toggles every HALF_TICKS cycles.
- Transitions:
  - EMPTY→SHOW_HI on capture.
  - SHOW_HI→SHOW_LO after HALF_TICKS cycles.
  - SHOW_LO→FREE after HALF_TICKS cycles.
  - FREE→SHOW_HI on capture.
- Every capture clears the half counter and forces `half_sel`=0.
- `result_ready` is combinational from state only, never from `result_valid`.
- `result_valid` while ready=0 is ignored. The producer holds valid and data until ready.
- The half counter runs 0..HALF_TICKS-1 and wraps.
- The scan counter runs 0..SCAN_TICKS-1. At wrap, the digit index (2 bits) increments 0→1→2→3→0; it runs freely in all states.
- Lit digit k: `an[k]`=0, others 1, `seg` = hex decode of `display[4k+3:4k]`.
- Hex decode, active-low gfedcba: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E, standard glyphs elsewhere.

## Timing

- Reset values: `display`=0, `half_sel`=0, `seg`=7'h7F, `an`=4'hF, `result_ready`=1. State is EMPTY; all counters and `value` are 0.
- `display` updates one cycle after a capture or `half_sel` change, so capture at edge N gives `display`=`result[31:16]` after edge N+1.
- `seg`/`an` are registered. They lag the digit index and `display` by one cycle.
- Minimum show: after capture at edge N, `result_ready` returns to 1 after edge N+2·HALF_TICKS.
- In FREE, a capture on the same edge as a half-counter wrap wins: `half_sel`=0 and the counter is 0.
- `rst_n` low mid-show discards `value`, returns to EMPTY, and blanks the display on that edge.

## Configuration

- `RDD_ZERO_BLANK_EN` defined: leading zero nibbles of the current half are blanked (`an[k]` held 1) from digit 3 downward. Digit 0 is always lit, so 16'h0000 shows a single "0" and 16'h00A5 lights digits 1–0 only.
- `RDD_ZERO_BLANK_EN` undefined: all four digits are always lit in SHOW_HI/SHOW_LO/FREE.

## Test plan

Run with HALF_TICKS=4, SCAN_TICKS=2.

- Reset: hold `rst_n`=0 for 3 cycles with `result_valid`=1. Required: no capture, `an`=4'hF, `seg`=7'h7F, `display`=0, `result_ready`=1.
- Basic capture: `result`=32'h0000_0064 with valid. Required: `display`=16'h0000 for 4 cycles, then 16'h0064 for 4 cycles. `result_ready` is low exactly 8 cycles.
- Backpressure: present 32'hDEAD_BEEF while in SHOW_LO. Required: not captured until ready rises, then `display`=16'hDEAD, then 16'hBEEF.
- Scan: with `display`=16'h1A8F, observe 8 cycles. Required: `an` sequence E,D,B,7 each for 2 cycles; `seg` 7'h0E, 7'h00, 7'h08, 7'h79.
- Reset mid-show: assert `rst_n`=0 during SHOW_HI. Required: next edge is EMPTY with blank `an` and `display`=0.
- Zero blank: with `RDD_ZERO_BLANK_EN`, `display`=16'h0064 never drives `an[3]` or `an[2]` low. Without the macro, all four digits scan.

Source files
------------

// File: rtl/result_display_driver.sv
// Captures a 32-bit result via valid/ready, alternates its halves on `display`
// and scans them onto a 4-digit active-low hex display. Optional: RDD_ZERO_BLANK_EN.
module result_display_driver #(
    parameter int unsigned HALF_TICKS = 50000000,
    parameter int unsigned SCAN_TICKS = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        result_valid,
    input  logic [31:0] result,
    output logic        result_ready,
    output logic [15:0] display,
    output logic        half_sel,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int HW = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
    localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

    typedef enum logic [1:0] {EMPTY, SHOW_HI, SHOW_LO, FREE} state_t;

    state_t        state, state_next;
    logic [HW-1:0] half_cnt;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit;
    logic [31:0]   value;
    logic          capture, half_wrap, scan_wrap, blank;
    logic [3:0]    nibble;
    logic [6:0]    glyph;

    assign capture   = result_valid && result_ready;
    assign half_wrap = (half_cnt == HW'(HALF_TICKS - 1));
    assign scan_wrap = (scan_cnt == SW'(SCAN_TICKS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        result_ready = 1'b0;
        case (state)
            EMPTY: begin
                result_ready = 1'b1;
                if (capture) state_next = SHOW_HI;
            end
            SHOW_HI: if (half_wrap) state_next = SHOW_LO;
            SHOW_LO: if (half_wrap) state_next = FREE;
            FREE: begin
                result_ready = 1'b1;
                if (capture) state_next = SHOW_HI;
            end
            default: state_next = EMPTY;
        endcase
    end

    // A capture outranks a coincident half-counter wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value    <= '0;
            half_cnt <= '0;
            half_sel <= 1'b0;
        end else if (capture) begin
            value    <= result;
            half_cnt <= '0;
            half_sel <= 1'b0;
        end else if (state != EMPTY) begin
            if (half_wrap) begin
                half_cnt <= '0;
                half_sel <= ~half_sel;
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            digit    <= 2'd0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) display <= '0;
        else        display <= half_sel ? value[15:0] : value[31:16];
    end

    always_comb begin
        nibble = display[{digit, 2'b00} +: 4];
        blank  = 1'b0;
`ifdef RDD_ZERO_BLANK_EN
        case (digit)
            2'd3:    blank = (display[15:12] == 4'h0);
            2'd2:    blank = (display[15:8] == 8'h00);
            2'd1:    blank = (display[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`endif
        case (nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state == EMPTY || blank) begin
            seg <= 7'h7F;
            an  <= 4'hF;
        end else begin
            seg <= glyph;
            an  <= ~(4'b0001 << digit);
        end
    end

endmodule
